// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding, field codes and branch-condition helpers for cpu_ctrl_fsm
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD, S_DECODE,
        S_GETA, S_GETB, S_ALU, S_WREG, S_COMP, S_WIMM,
        S_MLA, S_MLB, S_CADDR, S_LADDR, S_FETCH, S_M2R, S_WMEM,
        S_BR, S_HALT, S_ERROR
    } state_t;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_LDR    = 3'b011;
    localparam logic [2:0] OPC_STR    = 3'b100;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_IF1) || (s == S_FETCH) || (s == S_WMEM);
    endfunction

    function automatic logic cond_legal(input logic [2:0] c);
        return c <= 3'b100;
    endfunction

    // flags are {N,V,Z}
    function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
        logic lt;
        lt = f[2] ^ f[1];
        case (c)
            3'b000:  return 1'b1;
            3'b001:  return f[0];
            3'b010:  return !f[0];
            3'b011:  return lt;
            3'b100:  return lt | f[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - per-access mem_rdy wait counter; expired flags the last allowed wait cycle
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // saturates at LAST so an idle enable outside a wait state never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multicycle RISC control FSM with mem_rdy handshake and timeout
// Optional conditional branches enabled by defining CPU_CTRL_BRANCH_EN.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int NSEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [1:0]        in_sh,
    input  logic [2:0]        cond,
    input  logic [2:0]        nvz,
    input  logic              mem_rdy,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              write,
    output logic [NSEL_W-1:0] nsel,
    output logic [1:0]        vsel,
    output logic [1:0]        sel,
    output logic [1:0]        sh,
    output logic              reset_pc,
    output logic              load_pc,
    output logic              addr_sel,
    output logic              load_ir,
    output logic              load_addr,
    output logic              pc_sel,
    output logic [1:0]        mem_cmd,
    output logic              halted,
    output logic [1:0]        err
);

    localparam logic [NSEL_W-1:0] NSEL_RN = NSEL_W'(1);
    localparam logic [NSEL_W-1:0] NSEL_RM = NSEL_W'(2);
    localparam logic [NSEL_W-1:0] NSEL_RD = NSEL_W'(1) << (NSEL_W - 1);

    state_t     state, state_next;
    logic [1:0] err_next;
    logic       illegal;
    logic       expired;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_next != state),
        .en      (is_wait_state(state) && !mem_rdy),
        .expired (expired)
    );

`ifndef CPU_CTRL_BRANCH_EN
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{cond, nvz};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            err   <= ERR_NONE;
        end else begin
            state <= state_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = err;
        illegal    = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        write      = 1'b0;
        nsel       = '0;
        vsel       = VSEL_C;
        sel        = 2'b00;
        sh         = 2'b00;
        reset_pc   = 1'b0;
        load_pc    = 1'b0;
        addr_sel   = 1'b0;
        load_ir    = 1'b0;
        load_addr  = 1'b0;
        pc_sel     = 1'b0;
        mem_cmd    = MEM_NONE;
        halted     = 1'b0;

        case (state)
            S_RST: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                state_next = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                if (mem_rdy) state_next = S_IF2;
                else if (expired) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                load_ir    = 1'b1;
                state_next = S_UPD;
            end
            S_UPD: begin
                load_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OPC_MOV: begin
                        if (op == 2'b10) state_next = S_WIMM;
                        else if (op == 2'b00) state_next = S_GETA;
                        else illegal = 1'b1;
                    end
                    OPC_ALU:          state_next = S_GETA;
                    OPC_LDR, OPC_STR: state_next = S_MLA;
                    OPC_HALT:         state_next = S_HALT;
`ifdef CPU_CTRL_BRANCH_EN
                    OPC_BRANCH: begin
                        if (op == 2'b00 && cond_legal(cond))
                            state_next = cond_met(cond, nvz) ? S_BR : S_IF1;
                        else
                            illegal = 1'b1;
                    end
`endif
                    default:          illegal = 1'b1;
                endcase
                if (illegal) begin
                    state_next = S_ERROR;
                    err_next   = ERR_ILLEGAL;
                end
            end
            S_GETA: begin
                loada      = 1'b1;
                nsel       = NSEL_RN;
                state_next = S_GETB;
            end
            S_GETB: begin
                loadb      = 1'b1;
                nsel       = NSEL_RM;
                state_next = (opcode == OPC_ALU && op == 2'b01) ? S_COMP : S_ALU;
            end
            S_ALU: begin
                loadc      = 1'b1;
                sh         = in_sh;
                sel        = (opcode == OPC_MOV || op == 2'b11) ? 2'b01 : 2'b00;
                state_next = S_WREG;
            end
            S_WREG: begin
                write      = 1'b1;
                nsel       = NSEL_RD;
                vsel       = VSEL_C;
                state_next = S_IF1;
            end
            S_COMP: begin
                loads      = 1'b1;
                sh         = in_sh;
                state_next = S_IF1;
            end
            S_WIMM: begin
                write      = 1'b1;
                nsel       = NSEL_RN;
                vsel       = VSEL_IMM;
                state_next = S_IF1;
            end
            S_MLA: begin
                loada      = 1'b1;
                nsel       = NSEL_RN;
                state_next = (opcode == OPC_STR) ? S_MLB : S_CADDR;
            end
            S_MLB: begin
                loadb      = 1'b1;
                nsel       = NSEL_RD;
                state_next = S_CADDR;
            end
            S_CADDR: begin
                loadc      = 1'b1;
                sel        = 2'b10;
                state_next = S_LADDR;
            end
            S_LADDR: begin
                // a store reuses this cycle to move Rd data into C for the write
                load_addr = 1'b1;
                if (opcode == OPC_STR) begin
                    loadc = 1'b1;
                    sel   = 2'b01;
                end
                state_next = (opcode == OPC_LDR) ? S_FETCH : S_WMEM;
            end
            S_FETCH: begin
                mem_cmd = MEM_READ;
                if (mem_rdy) state_next = S_M2R;
                else if (expired) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_M2R: begin
                mem_cmd    = MEM_READ;
                write      = 1'b1;
                nsel       = NSEL_RD;
                vsel       = VSEL_MDATA;
                state_next = S_IF1;
            end
            S_WMEM: begin
                mem_cmd = MEM_WRITE;
                if (mem_rdy) state_next = S_IF1;
                else if (expired) begin
                    state_next = S_ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_BR: begin
`ifdef CPU_CTRL_BRANCH_EN
                pc_sel  = 1'b1;
                load_pc = 1'b1;
`endif
                state_next = S_IF1;
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed-vector bench for cpu_ctrl_fsm built with TIMEOUT=4
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [1:0] in_sh = 2'b00;
    logic [2:0] cond = 3'b000;
    logic [2:0] nvz = 3'b000;
    logic       mem_rdy = 1'b1;
    logic       loada, loadb, loadc, loads, write;
    logic [2:0] nsel;
    logic [1:0] vsel, sel, sh;
    logic       reset_pc, load_pc, addr_sel, load_ir, load_addr, pc_sel;
    logic [1:0] mem_cmd;
    logic       halted;
    logic [1:0] err;

    int n_vec = 0;
    int n_err = 0;

    cpu_ctrl_fsm #(.TIMEOUT(4), .NSEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .op(op), .in_sh(in_sh),
        .cond(cond), .nvz(nvz), .mem_rdy(mem_rdy),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
        .nsel(nsel), .vsel(vsel), .sel(sel), .sh(sh),
        .reset_pc(reset_pc), .load_pc(load_pc), .addr_sel(addr_sel),
        .load_ir(load_ir), .load_addr(load_addr), .pc_sel(pc_sel),
        .mem_cmd(mem_cmd), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    logic [24:0] outs;
    assign outs = {loada, loadb, loadc, loads, write, nsel, vsel, sel, sh,
                   reset_pc, load_pc, addr_sel, load_ir, load_addr, pc_sel,
                   mem_cmd, halted, err};

    // ld={loada,loadb,loadc,loads,write}  pc={reset_pc,load_pc,addr_sel,load_ir,load_addr}
    function automatic logic [24:0] ov(input logic [4:0] ld, input logic [2:0] ns,
                                       input logic [1:0] vs, input logic [1:0] sl,
                                       input logic [1:0] shf, input logic [4:0] pc,
                                       input logic ps, input logic [1:0] mc,
                                       input logic h, input logic [1:0] er);
        return {ld, ns, vs, sl, shf, pc, ps, mc, h, er};
    endfunction

    localparam logic [24:0] E_RST     = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b11000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_IF1     = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00100, 1'b0, 2'b01, 1'b0, 2'b00);
    localparam logic [24:0] E_IF2     = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00110, 1'b0, 2'b01, 1'b0, 2'b00);
    localparam logic [24:0] E_UPD     = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b01000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_DEC     = 25'd0;
    localparam logic [24:0] E_WIMM    = ov(5'b00001, 3'b001, 2'b10, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_GETA    = ov(5'b10000, 3'b001, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_GETB    = ov(5'b01000, 3'b010, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_ALU_ADD = ov(5'b00100, 3'b000, 2'b00, 2'b00, 2'b01, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_ALU_MOV = ov(5'b00100, 3'b000, 2'b00, 2'b01, 2'b11, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_WREG    = ov(5'b00001, 3'b100, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_COMP    = ov(5'b00010, 3'b000, 2'b00, 2'b00, 2'b10, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_MLB     = ov(5'b01000, 3'b100, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_CADDR   = ov(5'b00100, 3'b000, 2'b00, 2'b10, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_LADDR_L = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00001, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_LADDR_S = ov(5'b00100, 3'b000, 2'b00, 2'b01, 2'b00, 5'b00001, 1'b0, 2'b00, 1'b0, 2'b00);
    localparam logic [24:0] E_FETCH   = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b01, 1'b0, 2'b00);
    localparam logic [24:0] E_M2R     = ov(5'b00001, 3'b100, 2'b11, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b01, 1'b0, 2'b00);
    localparam logic [24:0] E_WMEM    = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b10, 1'b0, 2'b00);
    localparam logic [24:0] E_HALT    = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b1, 2'b00);
    localparam logic [24:0] E_ERR_TO  = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b01);
    localparam logic [24:0] E_ERR_IL  = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0, 2'b10);
    localparam logic [24:0] E_BR      = ov(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 5'b01000, 1'b1, 2'b00, 1'b0, 2'b00);

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // sample on the falling edge, then set mem_rdy for the coming rising edge
    task automatic step(input string tag, input logic [24:0] e, input logic rdy);
        @(negedge clk);
        check(tag, outs, e);
        mem_rdy = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        mem_rdy = 1'b1;
        #1 check("reset", outs, E_RST);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ir(input logic [2:0] oc, input logic [1:0] o, input logic [1:0] s);
        opcode = oc;
        op     = o;
        in_sh  = s;
    endtask

    task automatic front();
        step("if1", E_IF1, 1'b1);
        step("if2", E_IF2, 1'b1);
        step("upd", E_UPD, 1'b1);
        step("dec", E_DEC, 1'b1);
    endtask

    initial begin
        // MOV R1,#5
        set_ir(3'b110, 2'b10, 2'b00);
        do_reset();
        front();
        step("wimm", E_WIMM, 1'b1);

        // ADD with 3 stalled IF1 cycles; 4th cycle hits the timeout boundary with mem_rdy=1
        set_ir(3'b101, 2'b00, 2'b01);
        for (int i = 0; i < 3; i++) step("if1_wait", E_IF1, 1'b0);
        front();
        step("add_geta", E_GETA, 1'b1);
        step("add_getb", E_GETB, 1'b1);
        step("add_alu", E_ALU_ADD, 1'b1);
        step("add_wreg", E_WREG, 1'b1);

        // CMP
        set_ir(3'b101, 2'b01, 2'b10);
        front();
        step("cmp_geta", E_GETA, 1'b1);
        step("cmp_getb", E_GETB, 1'b1);
        step("cmp_comp", E_COMP, 1'b1);

        // MOV Rd,Rm with shift
        set_ir(3'b110, 2'b00, 2'b11);
        front();
        step("movr_geta", E_GETA, 1'b1);
        step("movr_getb", E_GETB, 1'b1);
        step("movr_alu", E_ALU_MOV, 1'b1);
        step("movr_wreg", E_WREG, 1'b1);

        // LDR
        set_ir(3'b011, 2'b00, 2'b00);
        front();
        step("ldr_mla", E_GETA, 1'b1);
        step("ldr_caddr", E_CADDR, 1'b1);
        step("ldr_laddr", E_LADDR_L, 1'b1);
        step("ldr_fetch", E_FETCH, 1'b1);
        step("ldr_m2r", E_M2R, 1'b1);

        // STR completing normally
        set_ir(3'b100, 2'b00, 2'b00);
        front();
        step("str_mla", E_GETA, 1'b1);
        step("str_mlb", E_MLB, 1'b1);
        step("str_caddr", E_CADDR, 1'b1);
        step("str_laddr", E_LADDR_S, 1'b1);
        step("str_wmem", E_WMEM, 1'b1);

        // STR timing out in WMEM after 4 cycles
        front();
        step("sto_mla", E_GETA, 1'b1);
        step("sto_mlb", E_MLB, 1'b1);
        step("sto_caddr", E_CADDR, 1'b1);
        step("sto_laddr", E_LADDR_S, 1'b0);
        for (int i = 0; i < 4; i++) step("sto_wmem", E_WMEM, 1'b0);
        step("sto_err", E_ERR_TO, 1'b1);
        for (int i = 0; i < 3; i++) step("sto_err_hold", E_ERR_TO, i[0]);

        // HALT held 20 cycles
        set_ir(3'b111, 2'b00, 2'b00);
        do_reset();
        front();
        for (int i = 0; i < 20; i++) step("halt", E_HALT, i[0]);

        // async reset in the middle of a stalled FETCH
        set_ir(3'b011, 2'b00, 2'b00);
        do_reset();
        front();
        step("ar_mla", E_GETA, 1'b1);
        step("ar_caddr", E_CADDR, 1'b1);
        step("ar_laddr", E_LADDR_L, 1'b0);
        step("ar_fetch", E_FETCH, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("ar_async", outs, E_RST);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_rdy = 1'b1;
        step("ar_if1", E_IF1, 1'b1);

`ifdef CPU_CTRL_BRANCH_EN
        // BEQ taken, then not taken, then an illegal condition
        set_ir(3'b001, 2'b00, 2'b00);
        cond = 3'b001;
        nvz  = 3'b001;
        step("beq_if2", E_IF2, 1'b1);
        step("beq_upd", E_UPD, 1'b1);
        step("beq_dec", E_DEC, 1'b1);
        step("beq_br", E_BR, 1'b1);
        nvz = 3'b000;
        front();
        step("bne_if1", E_IF1, 1'b1);
        cond = 3'b101;
        step("bad_if2", E_IF2, 1'b1);
        step("bad_upd", E_UPD, 1'b1);
        step("bad_dec", E_DEC, 1'b1);
        step("bad_err", E_ERR_IL, 1'b1);
`else
        // opcode 001 is illegal without branch support
        set_ir(3'b001, 2'b00, 2'b00);
        cond = 3'b001;
        nvz  = 3'b001;
        step("b_if2", E_IF2, 1'b1);
        step("b_upd", E_UPD, 1'b1);
        step("b_dec", E_DEC, 1'b1);
        step("b_err", E_ERR_IL, 1'b1);
        step("b_err_hold", E_ERR_IL, 1'b1);
`endif

        // opcode 000 is always illegal
        set_ir(3'b000, 2'b00, 2'b00);
        do_reset();
        front();
        step("ill_err", E_ERR_IL, 1'b1);
        step("ill_err_hold", E_ERR_IL, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
